// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - single-outstanding AXI4 INCR burst master; optional response checking via AXI_MASTER_RESP_CHECK_EN
module axi_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = 4,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // command
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  // write stream
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  // read stream
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  // completion
  output logic                  done,
  output logic                  done_err,
  // AW
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  // W
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  // B
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // AR
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // R
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [2:0] AXSIZE = 3'($clog2(STRB_WIDTH));

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  init_q;   // holds cmd_ready low until the first edge after reset
  logic                  done_q;
  logic                  cmd_hs, w_hs, b_hs, r_hs, burst_end;

  assign cmd_hs    = cmd_valid & cmd_ready;
  assign w_hs      = m_axi_wvalid & m_axi_wready;
  assign b_hs      = m_axi_bvalid & m_axi_bready;
  assign r_hs      = m_axi_rvalid & m_axi_rready;
  assign burst_end = b_hs | (r_hs & m_axi_rlast);

  // Address channels always present the latched command; only valid depends on state
  assign m_axi_awid    = id_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = AXSIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arid    = id_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AXSIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;

  assign m_axi_wdata = wr_data;
  assign m_axi_wstrb = wr_strb;
  assign rd_data     = m_axi_rdata;
  assign done        = done_q;

  // Burst sequencer: next state plus all handshake gating for the current state
  always_comb begin
    state_nx      = state;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    wr_ready      = 1'b0;
    m_axi_bready  = 1'b0;
    rd_valid      = 1'b0;
    rd_last       = 1'b0;
    m_axi_rready  = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = init_q;
        if (cmd_valid && init_q) state_nx = cmd_write ? S_AW : S_AR;
      end
      S_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nx = S_W;
      end
      S_W: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        m_axi_wlast  = (cnt_q == 8'd0);
        if (wr_valid && m_axi_wready && cnt_q == 8'd0) state_nx = S_B;
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nx = S_IDLE;
      end
      S_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nx = S_R;
      end
      S_R: begin
        rd_valid     = m_axi_rvalid;
        rd_last      = m_axi_rlast;
        m_axi_rready = rd_ready;
        if (m_axi_rvalid && rd_ready && m_axi_rlast) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, latched command fields, beat counter and the registered done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      addr_q <= '0;
      len_q  <= '0;
      id_q   <= '0;
      cnt_q  <= '0;
      init_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      init_q <= 1'b1;
      done_q <= burst_end;
      if (cmd_hs) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        id_q   <= cmd_id;
        cnt_q  <= cmd_len;
      end else if (w_hs || r_hs) begin
        cnt_q <= cnt_q - 8'd1;
      end
    end
  end

`ifdef AXI_MASTER_RESP_CHECK_EN
  logic err_q, done_err_q, beat_err;

  // Flags a bad response, foreign ID or misplaced rlast on the current handshake
  always_comb begin
    beat_err = 1'b0;
    if (b_hs)
      beat_err = (m_axi_bresp != 2'b00) || (m_axi_bid != id_q);
    else if (r_hs)
      beat_err = (m_axi_rresp != 2'b00) || (m_axi_rid != id_q) ||
                 (m_axi_rlast != (cnt_q == 8'd0));
  end

  // Sticky error for the burst in flight, reported alongside done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      if (cmd_hs) err_q <= 1'b0;
      else if (beat_err) err_q <= 1'b1;
      done_err_q <= burst_end & (err_q | beat_err);
    end
  end

  assign done_err = done_err_q;
`else
  logic unused_resp;
  assign unused_resp = ^{m_axi_bid, m_axi_bresp, m_axi_rid, m_axi_rresp};
  assign done_err    = 1'b0;
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
// tb/tb_axi_burst_master.sv - bench for axi_burst_master with a RAM-backed AXI slave and reference memory
module tb_axi_burst_master;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr, cmd_len, cmd_id;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_last, rd_valid, rd_ready, done, done_err;
  logic [7:0]  awid, awaddr, awlen, arid, araddr, arlen;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, arburst;
  logic        awlock, arlock;
  logic [3:0]  awcache, arcache;
  logic        awvalid, awready, arvalid, arready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [7:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready;
  logic [31:0] rdata;
  logic        rlast, rvalid, rready;

  axi_burst_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .done_err(done_err),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got no response within bound, expected completion", name);
  endtask

  // reference memory: word-addressed view of the 256-byte space
  logic [31:0] ref_mem [64];
  logic [31:0] smem [64];

  task automatic ref_write(input int word, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[word % 64][8*b +: 8] = d[8*b +: 8];
  endtask

  // slave knobs and expectations for the address phase
  int         w_mode = 0;
  int         rd_gap_pct = 0;
  logic [1:0] inj_bresp = 2'b00, inj_rresp = 2'b00;
  bit         inj_badid = 1'b0;
  bit         exp_wr;
  logic [7:0] exp_addr, exp_len, exp_id;
  int         b_hs_cyc = -10, r_last_cyc = -10;

  // AXI slave: drives at negedge, observes handshakes just before the next rising edge
  initial begin
    bit         b_pend, b_taken, r_act, r_taken;
    int         b_delay, wbeat, rbeat;
    logic [7:0] s_addr, s_len, s_id;
    b_pend = 0; b_taken = 0; r_act = 0; r_taken = 0; b_delay = 0; wbeat = 0; rbeat = 0;
    s_addr = 0; s_len = 0; s_id = 0;
    awready = 0; arready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
    rvalid = 0; rid = 0; rresp = 0; rdata = 0; rlast = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        b_pend = 0; b_taken = 0; r_act = 0; r_taken = 0;
        awready = 0; arready = 0; wready = 0; bvalid = 0; rvalid = 0; rlast = 0;
      end else begin
        awready = ($urandom_range(3) != 0);
        arready = ($urandom_range(3) != 0);
        wready  = (w_mode == 0) ? 1'b1 : (w_mode == 1) ? ~wready : 1'($urandom_range(1));
        if (b_taken) begin bvalid = 0; b_taken = 0; end
        if (b_pend && !bvalid) begin
          if (b_delay > 0) b_delay--;
          else begin
            bvalid = 1; bresp = inj_bresp; bid = inj_badid ? (s_id ^ 8'h01) : s_id;
          end
        end
        if (r_taken) begin rvalid = 0; r_taken = 0; end
        if (r_act && !rvalid && int'($urandom_range(99)) >= rd_gap_pct) begin
          rvalid = 1;
          rdata  = smem[(int'(s_addr >> 2) + rbeat) % 64];
          rlast  = (rbeat == int'(s_len));
          rresp  = inj_rresp;
          rid    = inj_badid ? (s_id ^ 8'h01) : s_id;
        end
      end
      #4;
      if (rst_n) begin
        if (awvalid && awready) begin
          check("aw_expected", 64'(exp_wr), 64'd1);
          check("awaddr", awaddr, exp_addr);
          check("awlen", awlen, exp_len);
          check("awid", awid, exp_id);
          check("aw_consts", {awsize, awburst, awlock, awcache, awprot}, {3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
          s_addr = awaddr; s_len = awlen; s_id = awid; wbeat = 0;
        end
        if (wvalid && wready) begin
          check("wlast", wlast, 64'(wbeat == int'(s_len)));
          for (int b = 0; b < 4; b++)
            if (wstrb[b]) smem[(int'(s_addr >> 2) + wbeat) % 64][8*b +: 8] = wdata[8*b +: 8];
          wbeat++;
          if (wbeat == int'(s_len) + 1) begin b_pend = 1; b_delay = $urandom_range(2); end
        end
        if (bvalid && bready) begin b_taken = 1; b_pend = 0; b_hs_cyc = cyc; end
        if (arvalid && arready) begin
          check("ar_expected", 64'(exp_wr), 64'd0);
          check("araddr", araddr, exp_addr);
          check("arlen", arlen, exp_len);
          check("arid", arid, exp_id);
          check("ar_consts", {arsize, arburst, arlock, arcache, arprot}, {3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
          s_addr = araddr; s_len = arlen; s_id = arid; rbeat = 0; r_act = 1;
        end
        if (rvalid && rready) begin
          r_taken = 1; rbeat++;
          if (rlast) begin r_act = 0; r_last_cyc = cyc; end
        end
      end
    end
  end

  task automatic send_cmd(input bit wr, input logic [7:0] addr, input logic [7:0] len,
                          input logic [7:0] id, output bit ok);
    exp_wr = wr; exp_addr = addr; exp_len = len; exp_id = id;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
    ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      #4; ok = cmd_ready;
      @(negedge clk);
    end
    cmd_valid = 0;
  endtask

  task automatic run_burst(input bit wr, input logic [7:0] addr, input logic [7:0] len,
                           input logic [7:0] id, input logic [31:0] dbase, input logic [3:0] strb,
                           input int stall, input bit err_if_checked, input string tag);
    bit ok, seen, pend, exp_err;
    int i, k;
`ifdef AXI_MASTER_RESP_CHECK_EN
    exp_err = err_if_checked;
`else
    exp_err = 1'b0;
`endif
    send_cmd(wr, addr, len, id, ok);
    if (!ok) begin fail_timeout({tag, " cmd"}); return; end
    check({tag, " avalid"}, wr ? awvalid : arvalid, 64'd1);
    check({tag, " cmd_ready_busy"}, cmd_ready, 64'd0);
    i = 0; k = 0; seen = 0; pend = 0;
    for (int t = 0; t < 600 && !seen; t++) begin
      if (wr) begin
        if (!pend) begin
          if (i <= int'(len) && int'($urandom_range(99)) >= stall) begin
            wr_valid = 1; wr_data = dbase + 32'(i); wr_strb = strb;
          end else wr_valid = 0;
        end
      end else rd_ready = (int'($urandom_range(99)) >= stall);
      #4;
      if (wr) begin
        if (wr_valid && wr_ready) begin
          ref_write(int'(addr >> 2) + i, wr_data, wr_strb); i++; pend = 0;
        end else pend = wr_valid;
      end else if (rd_valid && rd_ready) begin
        check({tag, " rd_data"}, rd_data, ref_mem[(int'(addr >> 2) + k) % 64]);
        check({tag, " rd_last"}, rd_last, 64'(k == int'(len)));
        k++;
      end
      if (done) begin
        seen = 1;
        check({tag, " beats"}, wr ? i : k, int'(len) + 1);
        check({tag, " done_err"}, done_err, 64'(exp_err));
        check({tag, " done_latency"}, cyc, (wr ? b_hs_cyc : r_last_cyc) + 1);
        check({tag, " cmd_ready_at_done"}, cmd_ready, 64'd1);
      end
      @(negedge clk);
    end
    wr_valid = 0; rd_ready = 0;
    if (!seen) begin fail_timeout({tag, " done"}); return; end
    #4;
    check({tag, " done_pulse_width"}, done, 64'd0);
  endtask

  typedef struct {
    bit wr; logic [7:0] addr; logic [7:0] len; logic [7:0] id; logic [31:0] dbase;
    logic [3:0] strb; int stall; int wmode; int rgap; logic [1:0] bresp; logic [1:0] rresp;
    bit badid; bit err;
  } vec_t;

  initial begin
    vec_t vecs[10];
    bit   ok, aborted;
    int   i;
    vecs[0] = '{1, 8'h10, 8'd3, 8'h5A, 32'hA0,       4'hF, 0,  0, 0,  2'b00, 2'b00, 0, 0};
    vecs[1] = '{0, 8'h10, 8'd3, 8'h5A, 32'h0,        4'hF, 0,  0, 0,  2'b00, 2'b00, 0, 0};
    vecs[2] = '{1, 8'h40, 8'd0, 8'h11, 32'h12345678, 4'hF, 0,  1, 0,  2'b00, 2'b00, 0, 0};
    vecs[3] = '{0, 8'h40, 8'd0, 8'h11, 32'h0,        4'hF, 75, 0, 0,  2'b00, 2'b00, 0, 0};
    vecs[4] = '{1, 8'h20, 8'd1, 8'h22, 32'hCAFE0000, 4'hF, 0,  0, 0,  2'b10, 2'b00, 0, 1};
    vecs[5] = '{1, 8'h20, 8'd1, 8'h23, 32'hBEEF0000, 4'h5, 0,  0, 0,  2'b00, 2'b00, 0, 0};
    vecs[6] = '{0, 8'h20, 8'd1, 8'h24, 32'h0,        4'hF, 0,  0, 0,  2'b00, 2'b10, 0, 1};
    vecs[7] = '{0, 8'h20, 8'd1, 8'h25, 32'h0,        4'hF, 0,  0, 0,  2'b00, 2'b00, 1, 1};
    vecs[8] = '{1, 8'h30, 8'd7, 8'h33, 32'h11110000, 4'hF, 40, 2, 0,  2'b00, 2'b00, 0, 0};
    vecs[9] = '{0, 8'h30, 8'd7, 8'h33, 32'h0,        4'hF, 40, 0, 50, 2'b00, 2'b00, 0, 0};

    for (int n = 0; n < 64; n++) begin
      ref_mem[n] = 32'h0101_0101 * 32'(n);
      smem[n]    = 32'h0101_0101 * 32'(n);
    end
    rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
    wr_data = 0; wr_strb = 0; wr_valid = 0; rd_ready = 0;

    // reset state and cmd_ready release timing
    repeat (5) @(negedge clk);
    check("rst valids", {awvalid, arvalid, wvalid, bready, rready, rd_valid, wr_ready}, 64'd0);
    check("rst done", {done, done_err}, 64'd0);
    check("rst cmd_ready", cmd_ready, 64'd0);
    check("rst fields", {awaddr, awid, awlen, araddr, arid, arlen}, 64'd0);
    rst_n = 1;
    #1 check("cmd_ready before edge", cmd_ready, 64'd0);
    @(posedge clk);
    #1 check("cmd_ready after edge", cmd_ready, 64'd1);

    // directed table
    for (int n = 0; n < 10; n++) begin
      w_mode = vecs[n].wmode; rd_gap_pct = vecs[n].rgap;
      inj_bresp = vecs[n].bresp; inj_rresp = vecs[n].rresp; inj_badid = vecs[n].badid;
      run_burst(vecs[n].wr, vecs[n].addr, vecs[n].len, vecs[n].id, vecs[n].dbase,
                vecs[n].strb, vecs[n].stall, vecs[n].err, $sformatf("vec%0d", n));
    end
    inj_bresp = 0; inj_rresp = 0; inj_badid = 0;

    // randomized bursts over words 0..31
    for (int n = 0; n < 24; n++) begin
      int word, len;
      word = $urandom_range(31);
      len  = $urandom_range((31 - word) > 15 ? 15 : (31 - word));
      w_mode = $urandom_range(2); rd_gap_pct = $urandom_range(50);
      run_burst(1'($urandom_range(1)), 8'(word << 2), 8'(len), 8'($urandom), $urandom,
                4'($urandom_range(15, 1)), $urandom_range(50), 1'b0, $sformatf("rnd%0d", n));
    end

    // reset asserted while beat 2 of an 8-beat write is on the bus
    w_mode = 0; rd_gap_pct = 0;
    send_cmd(1'b1, 8'h80, 8'd7, 8'h77, ok);
    if (!ok) fail_timeout("abort cmd");
    i = 0; aborted = 0;
    for (int t = 0; t < 200 && ok && !aborted; t++) begin
      wr_valid = 1; wr_data = 32'h5500 + 32'(i); wr_strb = 4'hF;
      if (i == 1) begin
        #2 check("abort wvalid before", wvalid, 64'd1);
        rst_n = 0;
        #1;
        check("abort w handshake low", {wvalid, wr_ready}, 64'd0);
        check("abort others low", {awvalid, arvalid, bready, rready, rd_valid, cmd_ready}, 64'd0);
        aborted = 1;
      end else begin
        #4;
        if (wr_valid && wr_ready) begin ref_write(32 + i, wr_data, wr_strb); i++; end
        @(negedge clk);
      end
    end
    if (ok && !aborted) fail_timeout("abort beat2");
    wr_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 check("post-abort cmd_ready before edge", cmd_ready, 64'd0);
    @(posedge clk);
    #1 check("post-abort cmd_ready", cmd_ready, 64'd1);
    run_burst(1'b0, 8'h10, 8'd3, 8'h5A, 32'h0, 4'hF, 20, 1'b0, "post_abort_rd");
    run_burst(1'b1, 8'h00, 8'd2, 8'h01, 32'h600D0000, 4'hF, 20, 1'b0, "post_abort_wr");
    run_burst(1'b0, 8'h00, 8'd2, 8'h02, 32'h0, 4'hF, 0, 1'b0, "post_abort_rd2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
